// File: rtl/conv_kernel_mac.sv
// 11x7 kernel MAC sequencer: latches one pixel window, walks the weight SRAM one
// kernel per cycle and emits one ReLU'd, shifted, saturated byte per kernel.
module conv_kernel_mac #(
  parameter int NUM_KERNELS = 32,
  parameter int SHIFT       = 7
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start,
  input  logic [0:615]       window_in,
  output logic [4:0]         weight_addr,
  output logic               weight_en,
  input  logic [0:615]       weight_in,
  output logic               out_valid,
  output logic [4:0]         out_idx,
  output logic [7:0]         out_data,
  output logic signed [22:0] out_sum,
  output logic               busy,
  output logic               done
);

  localparam int         NPIX     = 77;
  localparam logic [4:0] LAST_IDX = 5'(NUM_KERNELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;
  logic [4:0] addr_q, addr_d;
  logic en_q, en_d, busy_q, busy_d;
  logic [0:615] win_q, win_d;

  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic [4:0] s1_idx_q, s2_idx_q, s3_idx_q;
  logic signed [15:0] prod_q [NPIX];
  logic signed [15:0] prod_d [NPIX];
  logic signed [22:0] sum_q, sum_d, shifted;

  logic out_valid_q, out_valid_d, done_q, done_d;
  logic [4:0] out_idx_q, out_idx_d;
  logic [7:0] out_data_q, out_data_d;
  logic signed [22:0] out_sum_q, out_sum_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    en_d    = en_q;
    busy_d  = busy_q;
    win_d   = win_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        addr_d  = '0;
        en_d    = 1'b1;
        busy_d  = 1'b1;
        win_d   = window_in;
      end
      RUN: if (addr_q == LAST_IDX) begin
        state_d = DRAIN;
        en_d    = 1'b0;
      end else begin
        addr_d = addr_q + 5'd1;
      end
      DRAIN: if (done_q) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Weights for the kernel issued last cycle are on weight_in now.
  always_comb begin
    for (int i = 0; i < NPIX; i++) begin
      prod_d[i] = prod_q[i];
      if (s1_valid_q)
        prod_d[i] = 16'($signed(win_q[8*i +: 8])) * 16'($signed(weight_in[8*i +: 8]));
    end
  end

  always_comb begin
    sum_d = sum_q;
    if (s2_valid_q) begin
      sum_d = '0;
      for (int i = 0; i < NPIX; i++) sum_d = sum_d + 23'(prod_q[i]);
    end
  end

  always_comb begin
    shifted     = sum_q >>> SHIFT;
    out_valid_d = s3_valid_q;
    done_d      = s3_valid_q && (s3_idx_q == LAST_IDX);
    out_idx_d   = out_idx_q;
    out_sum_d   = out_sum_q;
    out_data_d  = out_data_q;
    if (s3_valid_q) begin
      out_idx_d = s3_idx_q;
      out_sum_d = sum_q;
      if (sum_q < 0)                out_data_d = '0;
      else if (shifted > 23'sd127)  out_data_d = 8'd127;
      else                          out_data_d = shifted[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s2_idx_q    <= '0;
      s3_idx_q    <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      s1_valid_q  <= en_q;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      s1_idx_q    <= addr_q;
      s2_idx_q    <= s1_idx_q;
      s3_idx_q    <= s2_idx_q;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_sum_q   <= out_sum_d;
    end
  end

  // Datapath-only registers; qualified by the valid pipeline, so no reset needed.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    for (int i = 0; i < NPIX; i++) prod_q[i] <= prod_d[i];
  end

  assign weight_addr = addr_q;
  assign weight_en   = en_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;
  assign out_idx     = out_idx_q;
  assign out_data    = out_data_q;
  assign out_sum     = out_sum_q;

endmodule

// File: tb/tb_conv_kernel_mac.sv
// Scoreboard bench for conv_kernel_mac: expected results are queued at start and
// matched against each out_valid, with cycle-exact checks on the control outputs.
module tb_conv_kernel_mac;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_b, start;
  logic [0:615] window_in, weight_in;
  logic [4:0] weight_addr, out_idx;
  logic weight_en, out_valid, busy, done;
  logic [7:0] out_data;
  logic signed [22:0] out_sum;

  conv_kernel_mac #(.NUM_KERNELS(N), .SHIFT(7)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .window_in(window_in),
    .weight_addr(weight_addr), .weight_en(weight_en), .weight_in(weight_in),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
    .out_sum(out_sum), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; longint sum; int data; int cyc;} exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int run_s = -1000;
  bit chk_on = 1'b0;
  int pixv [77];
  logic signed [7:0] wmem [N][77];

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input longint s);
    longint q;
    if (s < 0) return 0;
    q = s >>> 7;
    return (q > 127) ? 127 : int'(q);
  endfunction

  // Weight SRAM: returns the addressed kernel one cycle after the address.
  always @(posedge clk)
    for (int i = 0; i < 77; i++) weight_in[8*i +: 8] <= wmem[weight_addr][i];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_on) begin
      bit exp_en;
      exp_en = (cyc >= run_s + 1) && (cyc <= run_s + N);
      if (out_valid) begin
        if (sb.size() == 0) check("spurious_valid", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("out_idx", out_idx, e.idx);
          check("out_sum", out_sum, e.sum);
          check("out_data", out_data, e.data);
          check("latency", cyc, e.cyc);
        end
      end
      check("busy", busy, (cyc >= run_s + 1) && (cyc <= run_s + 4 + N));
      check("weight_en", weight_en, exp_en);
      if (exp_en) check("weight_addr", weight_addr, cyc - run_s - 1);
      check("done", done, cyc == run_s + 4 + N);
    end
  end

  task automatic launch();
    @(negedge clk);
    for (int i = 0; i < 77; i++) window_in[8*i +: 8] = 8'(pixv[i]);
    start = 1'b1;
    run_s = cyc;
    for (int k = 0; k < N; k++) begin
      exp_t e;
      longint s = 0;
      for (int i = 0; i < 77; i++) s += longint'(pixv[i]) * longint'(wmem[k][i]);
      e.idx = k; e.sum = s; e.data = sat(s); e.cyc = run_s + 5 + k;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check("done_seen", seen, 1);
  endtask

  task automatic fill(input int p, input int w);
    for (int i = 0; i < 77; i++) pixv[i] = p;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 77; i++) wmem[k][i] = 8'(w);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, weight_addr, 0);
    check({tag, "_en"}, weight_en, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_sum"}, out_sum, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    rst_b = 1'b1;
    start = 1'b0;
    window_in = '0;
    fill(0, 0);
    #12;
    check_zero("rst");
    @(negedge clk);
    rst_b = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);

    fill(2, 64);                // sum 9856, data 77
    launch(); wait_done();

    fill(1, 0);                 // kernel k weights all k
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 77; i++) wmem[k][i] = 8'(k);
    launch(); wait_done();

    fill(1, -1);    launch(); wait_done();
    fill(127, 127); launch(); wait_done();
    fill(-128, -128); launch(); wait_done();

    for (int i = 0; i < 77; i++) pixv[i] = int'($signed(8'($urandom)));
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 77; i++) wmem[k][i] = 8'($urandom);
    launch(); wait_done();

    // Start while busy and in the done cycle must be ignored.
    fill(3, 5);
    for (int i = 0; i < 77; i++) pixv[i] = i - 38;
    launch();
    while (cyc < run_s + 10) @(negedge clk);
    for (int i = 0; i < 77; i++) window_in[8*i +: 8] = 8'(100 - i);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    for (int i = 0; i < 77; i++) window_in[8*i +: 8] = 8'hA5;
    start = 1'b1;
    fill(-7, 9);
    launch(); wait_done();

    // Reset mid-run aborts; then a fresh run must be complete.
    fill(2, 64);
    launch();
    for (int i = 0; i < 40 && weight_addr != 5'd10; i++) @(negedge clk);
    check("addr_reach_10", weight_addr, 10);
    #2;
    rst_b = 1'b1;
    run_s = -1000;
    sb.delete();
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    repeat (10) @(negedge clk);
    fill(4, -3);
    launch(); wait_done();
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_kernel_mac.md
# conv_kernel_mac

Kernel-sequencing multiply-accumulate engine for the 11x7 convolution layer. On a start pulse it latches one 11x7 window of 8-bit pixels, then issues one weight-SRAM read address per cycle to the 11x7 weight selector. It consumes the 77-weight kernel returned one cycle later and produces one ReLU'd, shifted, saturated 8-bit result per kernel. It sits directly downstream of the weight selector: it drives that block's address and enable, and consumes its weight bus.

## Interface
- NUM_KERNELS, 32, kernels per window; legal range 1..32; addresses issued 0..NUM_KERNELS-1
- SHIFT, 7, arithmetic right shift applied to the accumulated sum before saturation
- clk  in  1  clock; all state changes on rising edge
- rst_b  in  1  asynchronous, active-high reset. Despite the name, 1 = reset.
- start  in  1  one-cycle request; accepted only in IDLE
- window_in  in  616  77 signed 8-bit pixels; pixel i = window_in[8i : 8i+7], MSB at lower index. Sampled on the accepted start edge only.
- weight_addr  out  5  kernel index to weight selector (its cnt_in)
- weight_en  out  1  weight selector enable (its en); high only while issuing addresses
- weight_in  in  616  77 signed 8-bit weights, same packing as window_in; valid the cycle after the address/enable cycle
- out_valid  out  1  result strobe; no backpressure, downstream always accepts
- out_idx  out  5  kernel index of current result
- out_data  out  8  result in 0..127
- out_sum  out  23  signed raw dot product, for verification
- busy  out  1  high from first RUN cycle through the done cycle
- done  out  1  one-cycle pulse, coincident with the last out_valid

## Operation
- FSM states:
  - IDLE: start=1 → latch window_in, clear kernel counter, go to RUN.
  - RUN: weight_en=1, weight_addr=counter, counter++. After issuing NUM_KERNELS-1, go to DRAIN.
  - DRAIN: weight_en=0; wait until the last result is presented with done=1, then go to IDLE.
- start is ignored in RUN and DRAIN, including the done cycle. The latched window is never modified mid-run.
- Pipeline, each stage carrying a valid bit and kernel index:
  - S1: weight_in arrives from SRAM.
  - S2: 77 registered signed 8x8 products, 16 bits each.
  - S3: registered 23-bit signed sum. No overflow is possible: |sum| ≤ 77·16384 = 1,261,568 < 2^22.
  - S4: registered output.
- Post-process:
  - sum < 0 → out_data = 0.
  - Otherwise q = sum >>> SHIFT; out_data = min(q, 127).
  - out_sum = sum unmodified.
- When out_valid=0: out_data, out_idx and out_sum hold their last values; only out_valid is checked.
- Reset:
  - Asynchronous; FSM to IDLE; all pipeline valid bits cleared.
  - All outputs 0: weight_addr, weight_en, out_valid, out_idx, out_data, out_sum, busy, done.
  - Reset mid-run aborts the run: no out_valid after release until a new start is accepted.

## Timing
- start sampled high at the edge ending cycle s:
  - Cycle s+1+k: weight_addr=k, weight_en=1, for k = 0..NUM_KERNELS-1.
  - Cycle s+2+k: weight_in holds kernel k.
  - Cycle s+5+k: out_valid=1, out_idx=k. Latency is 4 cycles from address issue to result.
- Results are back-to-back, one per cycle, in ascending index order.
- done occurs at cycle s+4+NUM_KERNELS.
- busy is high for cycles s+1 .. s+4+NUM_KERNELS.
- Earliest next accepted start is at the edge ending cycle s+5+NUM_KERNELS.
- NUM_KERNELS=1: single address at s+1; out_valid and done together at s+5.

## Test plan
- Reset: assert rst_b mid-cycle asynchronously → all outputs 0 immediately; FSM in IDLE; no out_valid after release.
- Nominal: pixels all 2, SRAM model returns all weights 64 for every address, start at s → 32 results at s+5..s+36, each out_sum=9856, out_data=77; done only at s+36; busy high s+1..s+36; weight_en high exactly s+1..s+32.
- Index/latency: weights at address k all equal k, pixels all 1 → out_idx=k at s+5+k, out_sum=77k, out_data=(77k)>>7 (0 for k=0..1, 1 for k=2..3, ..., 18 for k=31).
- Sign/saturation:
  - pixels 1, weights -1 → out_sum=-77, out_data=0.
  - pixels 127, weights 127 → out_sum=1,241,933, out_data=127.
  - pixels -128, weights -128 → out_sum=1,261,568, out_data=127.
- Start while busy: pulse start at s+10 with a different window_in → ignored; all 32 results use the original window; a start in the cycle after done is accepted.
- Reset mid-run: assert rst_b while weight_addr=10 → outputs 0; no stray out_valid or done. A new start then yields 32 full results with the correct latency.
